// File: rtl/game_layer_compositor_if.sv
// game_layer_compositor_if: pixel, layer and game-event bundle between the VGA
// game path and the compositor.
interface game_layer_compositor_if #(
  parameter int N_LAYERS = 8,
  parameter int RGB_W = 12
);
  localparam int SEL_W = $clog2(N_LAYERS + 1);
  logic frame_start;
  logic [N_LAYERS-1:0] layer_en;
  logic [N_LAYERS*RGB_W-1:0] layer_rgb;
  logic [RGB_W-1:0] bg_rgb;
  logic [RGB_W-1:0] start_rgb;
  logic [RGB_W-1:0] over_rgb;
  logic [RGB_W-1:0] win_rgb;
  logic key_enter;
  logic player_hit;
  logic player_dead;
  logic boss_dead;
  logic [RGB_W-1:0] pix_rgb;
  logic [SEL_W-1:0] layer_sel;
  logic [1:0] game_state;
  logic play_active;
  logic invuln;
  modport master (
    output frame_start, layer_en, layer_rgb, bg_rgb, start_rgb, over_rgb, win_rgb,
    output key_enter, player_hit, player_dead, boss_dead,
    input pix_rgb, layer_sel, game_state, play_active, invuln
  );
  modport slave (
    input frame_start, layer_en, layer_rgb, bg_rgb, start_rgb, over_rgb, win_rgb,
    input key_enter, player_hit, player_dead, boss_dead,
    output pix_rgb, layer_sel, game_state, play_active, invuln
  );
endinterface

// File: rtl/game_layer_compositor.sv
// game_layer_compositor: prioritised colour-keyed sprite compositor with a
// frame-synchronous START/PLAY/OVER/WIN controller and hit-blink invulnerability.
module game_layer_compositor #(
  parameter int N_LAYERS = 8,
  parameter int RGB_W = 12,
  parameter int KEY_EN = 1,
  parameter logic [RGB_W-1:0] KEY_COLOR = '0,
  parameter int BLINK_FRAMES = 120,
  parameter int BLINK_SHIFT = 3
) (
  input logic clk,
  input logic rst,
  game_layer_compositor_if.slave io
);
  localparam int SEL_W = $clog2(N_LAYERS + 1);
  typedef enum logic [1:0] {START, PLAY, OVER, WIN} state_t;
  state_t state, state_n, pend_t, pend_t_n;
  logic pend_v, pend_v_n, enter_q, enter_rise, commit;
  logic [7:0] blink, blink_n;
  logic [N_LAYERS-1:0] vis;
  logic [RGB_W-1:0] rgb_n;
  logic [SEL_W-1:0] sel_n;
  assign enter_rise = io.key_enter & ~enter_q;
  assign commit = io.frame_start & pend_v;
  assign io.game_state = state;
  assign io.play_active = state == PLAY;
  assign io.invuln = |blink;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= START;
      pend_v <= 1'b0;
      pend_t <= START;
      blink <= '0;
      enter_q <= 1'b0;
      io.pix_rgb <= '0;
      io.layer_sel <= SEL_W'(N_LAYERS);
    end else begin
      state <= state_n;
      pend_v <= pend_v_n;
      pend_t <= pend_t_n;
      blink <= blink_n;
      enter_q <= io.key_enter;
      io.pix_rgb <= rgb_n;
      io.layer_sel <= sel_n;
    end
  // Events are judged against the state held this cycle; a committing request is
  // cleared first so a same-cycle event becomes the next pending request.
  always_comb begin
    state_n = commit ? pend_t : state;
    pend_v_n = pend_v & ~commit;
    pend_t_n = pend_t;
    if (state == PLAY && io.player_dead) begin
      pend_v_n = 1'b1;
      pend_t_n = OVER;
    end else if (state == PLAY && io.boss_dead && !(pend_v_n && pend_t == OVER)) begin
      pend_v_n = 1'b1;
      pend_t_n = WIN;
    end else if (state != PLAY && enter_rise) begin
      pend_v_n = 1'b1;
      pend_t_n = state == START ? PLAY : START;
    end
    blink_n = commit ? 8'd0
            : (io.player_hit && state == PLAY && blink == 8'd0) ? 8'(BLINK_FRAMES)
            : (io.frame_start && blink != 8'd0) ? blink - 8'd1 : blink;
  end
  always_comb begin
    for (int i = 0; i < N_LAYERS; i++)
      vis[i] = io.layer_en[i] && (KEY_EN == 0 || io.layer_rgb[i*RGB_W +: RGB_W] != KEY_COLOR);
    vis[0] = vis[0] & ~(blink != 8'd0 && blink[BLINK_SHIFT]);
    rgb_n = state == START ? io.start_rgb : state == OVER ? io.over_rgb
          : state == WIN ? io.win_rgb : io.bg_rgb;
    sel_n = SEL_W'(N_LAYERS);
    if (state == PLAY)
      for (int i = N_LAYERS - 1; i >= 0; i--)
        if (vis[i]) begin
          rgb_n = io.layer_rgb[i*RGB_W +: RGB_W];
          sel_n = SEL_W'(i);
        end
  end
endmodule

// File: doc/game_layer_compositor.md
Name: game_layer_compositor

Overview:
- Parametrised pixel compositor and game-phase controller for the VGA game path.
- Selects one colour per pixel from N prioritised sprite layers, with colour-key transparency, over a background; output is registered.
- Runs a frame-synchronous game FSM (START / PLAY / OVER / WIN) that picks the full-screen image or the composited scene.
- Adds player invulnerability blinking on layer 0.

Parameters:
- N_LAYERS, 8, number of sprite layers; index 0 has highest priority.
- RGB_W, 12, colour width per pixel.
- KEY_EN, 1, 1 = a layer pixel equal to KEY_COLOR is transparent.
- KEY_COLOR, 12'h000, transparent colour value (RGB_W bits).
- BLINK_FRAMES, 120, invulnerability length in frames after a hit (1..255).
- BLINK_SHIFT, 3, layer 0 hidden while blink_cnt[BLINK_SHIFT] = 1.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, asynchronous active-high reset.
- frame_start, input, 1, one-cycle pulse at the first pixel of each frame.
- layer_en, input, N_LAYERS, per-layer pixel hit at the current (x,y).
- layer_rgb, input, N_LAYERS*RGB_W, layer i colour at bits [i*RGB_W +: RGB_W].
- bg_rgb, input, RGB_W, background pixel.
- start_rgb, input, RGB_W, start-screen pixel.
- over_rgb, input, RGB_W, game-over-screen pixel.
- win_rgb, input, RGB_W, win-screen pixel.
- key_enter, input, 1, enter key level (already synchronous to clk).
- player_hit, input, 1, pulse: player took damage.
- player_dead, input, 1, pulse or level: player health reached 0.
- boss_dead, input, 1, pulse or level: boss destroyed.
- pix_rgb, output, RGB_W, registered composited pixel.
- layer_sel, output, clog2(N_LAYERS+1), registered winning layer index; N_LAYERS = background or full-screen image.
- game_state, output, 2, 0 START, 1 PLAY, 2 OVER, 3 WIN.
- play_active, output, 1, game_state == PLAY.
- invuln, output, 1, blink_cnt != 0.

Behaviour:
- Reset values: pix_rgb 0; layer_sel N_LAYERS; game_state START; pending none; blink_cnt 0; enter_q 0.

Enter detection:
- enter_q registers key_enter every cycle.
- enter_rise = key_enter & ~enter_q.

Pending request (one register, target + valid):
- START: enter_rise requests PLAY.
- PLAY: player_dead requests OVER. boss_dead requests WIN, unless OVER is already pending or player_dead is asserted in the same cycle. A pending OVER is never overwritten by WIN; a pending WIN is overwritten by a later player_dead.
- OVER / WIN: enter_rise requests START.
- Events not listed for the current state are ignored.

Commit:
- On frame_start with a request pending: game_state <= target and pending clears, so the state changes only on frame boundaries.
- An event in the same cycle as frame_start is latched as a new pending request and commits at the next frame_start.

Blink counter:
- blink_cnt is 8-bit.
- player_hit while PLAY && blink_cnt == 0 loads BLINK_FRAMES.
- Hits while blink_cnt != 0 are ignored (no reload).
- Decrements by 1 on each frame_start while nonzero, saturating at 0.
- Forced to 0 on any commit.
- player_hit and frame_start in the same cycle: the load wins.

Compositing (combinational, then registered):
- A layer is visible when its layer_en bit is 1 and (KEY_EN == 0 or its rgb != KEY_COLOR).
- Layer 0 is additionally masked when blink_cnt != 0 and blink_cnt[BLINK_SHIFT] == 1.
- In PLAY, the visible layer with the lowest index wins; if none is visible, bg_rgb is used with layer_sel = N_LAYERS.
- START, OVER and WIN output start_rgb, over_rgb and win_rgb respectively, with layer_sel = N_LAYERS.
- Latency: pix_rgb and layer_sel update exactly 1 clk after their inputs.
- game_state, play_active and invuln are registered state outputs.

Reset mid-frame:
- Outputs go to reset values immediately (asynchronous).
- The first valid request after reset deasserts still waits for a frame_start.

Test Plan:
- Reset, then key_enter held 1: no PLAY until a frame_start arrives; commit happens on that frame_start; holding enter further causes no second transition; pix_rgb equals start_rgb before the commit.
- PLAY with layer_en = 8'b0000_0110, layer1 = 12'h0F0, layer2 = 12'hF00 -> next cycle pix_rgb = 12'h0F0, layer_sel = 1. Same stimulus with layer1 = 12'h000 (KEY_EN = 1) -> pix_rgb = 12'hF00, layer_sel = 2. With layer_en = 0 -> pix_rgb = bg_rgb, layer_sel = 8.
- PLAY, player_hit pulse -> invuln = 1 and blink_cnt = 120. With layer_en[0] = 1, layer 0 is hidden in frames where blink_cnt[3] = 1. A second hit is ignored. invuln drops after 120 frame_starts.
- PLAY, player_dead and boss_dead in the same cycle -> state OVER at the next frame_start.
- PLAY, boss_dead then player_dead before the next frame_start -> state OVER.
- OVER, enter rising edge -> START at the next frame_start. Assert rst mid-frame while in PLAY -> state START, pix_rgb = 0, invuln = 0 immediately.
